grid_seeder: RTL and testbench

Loads the Game of Life cell grid with an initial pattern. It writes into the grid memory that the generation/display stage steps and scans out. Three modes are supported: full clear, pseudo-random fill at a selectable density, and toggling a single cell picked by the user. While `busy` is high, the grid owner must hold generation stepping and ignore its own writes.

---
 rtl/grid_seeder.sv | 179 +++++++++++++++++
 tb/tb_grid_seeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_seeder.sv
// Game of Life grid loader: clear, pseudo-random fill or single-cell toggle.
// Writes one cell per cycle into the grid memory while busy is held high.
module grid_seeder #(
    parameter int          WIDTH     = 80,
    parameter int          HEIGHT    = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [2:0]  density,
    input  logic [6:0]  cell_x,
    input  logic [5:0]  cell_y,
    output logic [12:0] rd_addr,
    input  logic        rd_data,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic        wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [6:0]  X_LAST = 7'(WIDTH - 1);
    localparam logic [5:0]  Y_LAST = 6'(HEIGHT - 1);
    localparam logic [6:0]  X_IMAX = 7'(WIDTH - 2);
    localparam logic [5:0]  Y_IMAX = 6'(HEIGHT - 2);
    localparam logic [12:0] A_LAST = 13'(WIDTH * HEIGHT - 1);
    localparam logic [12:0] W13    = 13'(WIDTH);
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [1:0]  M_RAND = 2'b01;
    localparam logic [1:0]  M_TOG  = 2'b10;

    typedef enum logic [2:0] {IDLE, SWEEP, TOG_RD, TOG_WR, FINISH} state_t;

    state_t      state, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  dens_q, dens_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [12:0] rd_addr_q, rd_addr_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic        wr_en_q, wr_en_d;
    logic        wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept, tog_ok;
    logic [12:0] tog_addr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Perimeter is always dead; interior is alive only in random mode.
    function automatic logic cell_val(input logic [6:0] x, input logic [5:0] y,
                                      input logic [1:0] m, input logic [2:0] dn,
                                      input logic [15:0] l);
        logic perim;
        perim = (x == 7'd0) || (x == X_LAST) || (y == 6'd0) || (y == Y_LAST);
        return !perim && (m == M_RAND) && (l[2:0] < dn);
    endfunction

    assign accept   = start && (state == IDLE || state == FINISH);
    assign tog_ok   = (cell_x >= 7'd1) && (cell_x <= X_IMAX) &&
                      (cell_y >= 6'd1) && (cell_y <= Y_IMAX);
    assign tog_addr = 13'(cell_y) * W13 + 13'(cell_x);

    always_comb begin
        state_d   = state;
        mode_d    = mode_q;
        dens_d    = dens_q;
        x_d       = x_q;
        y_d       = y_q;
        lfsr_d    = lfsr_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        wr_data_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state)
            SWEEP: begin
                if (wr_addr_q == A_LAST) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    if (x_q == X_LAST) begin
                        x_d = 7'd0;
                        y_d = y_q + 6'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                    wr_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    wr_addr_d = wr_addr_q + 13'd1;
                    wr_data_d = cell_val(x_d, y_d, mode_q, dens_q, lfsr_q);
                    lfsr_d    = lfsr_step(lfsr_q);
                end
            end
            TOG_RD: begin
                state_d   = TOG_WR;
                wr_en_d   = 1'b1;
                busy_d    = 1'b1;
                wr_addr_d = rd_addr_q;
            end
            TOG_WR: begin
                state_d = FINISH;
                done_d  = 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // FINISH accepts a new request so back-to-back operations lose no cycle.
        if (accept) begin
            mode_d = mode;
            dens_d = density;
            if (mode == M_TOG) begin
                if (tog_ok) begin
                    state_d   = TOG_RD;
                    busy_d    = 1'b1;
                    rd_addr_d = tog_addr;
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end else begin
                state_d   = SWEEP;
                x_d       = 7'd0;
                y_d       = 6'd0;
                wr_en_d   = 1'b1;
                busy_d    = 1'b1;
                wr_addr_d = 13'd0;
                wr_data_d = cell_val(7'd0, 6'd0, mode, density, lfsr_q);
                lfsr_d    = lfsr_step(lfsr_q);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mode_q    <= 2'b00;
            dens_q    <= 3'd0;
            x_q       <= 7'd0;
            y_q       <= 6'd0;
            lfsr_q    <= SEED;
            rd_addr_q <= 13'd0;
            wr_addr_q <= 13'd0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            dens_q    <= dens_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lfsr_q    <= lfsr_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    // The read data only arrives in the write cycle itself, so the toggle
    // value bypasses the output register.
    assign wr_data = (state == TOG_WR) ? ~rd_data : wr_data_q;

endmodule

// File: tb/tb_grid_seeder.sv
// Randomized scoreboard bench for grid_seeder against a cell-level grid/LFSR model.
module tb_grid_seeder;

    localparam int W = 80;
    localparam int H = 60;
    localparam int N = W * H;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        start    = 1'b0;
    logic [1:0]  mode     = 2'b00;
    logic [2:0]  density  = 3'd0;
    logic [6:0]  cell_x   = 7'd0;
    logic [5:0]  cell_y   = 6'd0;
    logic        rd_data  = 1'b0;
    logic [12:0] rd_addr;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic        wr_data;
    logic        busy;
    logic        done;

    grid_seeder dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .mode(mode),
        .density(density), .cell_x(cell_x), .cell_y(cell_y),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    typedef struct {int cyc; int addr; logic data;} wr_t;
    typedef struct {int cyc; int addr;} rd_t;

    wr_t         wq[$];
    rd_t         rq[$];
    int          dq[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        grid[0:N-1];
    logic        mem[0:8191];
    logic [15:0] m_lfsr = 16'hACE1;
    int          rd_model = 0;
    int          bf = 0;
    int          bt = 0;
    bit          fin = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Grid memory with synchronous read, as seen by the seeder.
    always @(posedge CLOCK_50) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    function automatic logic [15:0] galois(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here.
    always begin
        @(negedge CLOCK_50 or negedge resetn);
        if (!resetn) begin
            #1;
            chk("rst_wr_en", wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
        end else if (fin) begin
            chk("left_writes", wq.size(), 0);
            chk("left_done", dq.size(), 0);
            chk("left_rd", rq.size(), 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else begin
            chk("busy", busy, (cyc >= bf && cyc < bt) ? 1 : 0);
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk("write_missing_cyc", cyc, wq[0].cyc);
                void'(wq.pop_front());
            end
            if (wr_en) begin
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    chk("wr_addr", wr_addr, wq[0].addr);
                    chk("wr_data", wr_data, wq[0].data);
                    void'(wq.pop_front());
                end else begin
                    chk("unexpected_wr_en", wr_en, 0);
                end
            end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("wr_en", wr_en, 1);
                void'(wq.pop_front());
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
                chk("done_missing_cyc", cyc, dq[0]);
                void'(dq.pop_front());
            end
            if (done) begin
                if (dq.size() > 0 && dq[0] == cyc) begin
                    chk("done_cyc", cyc, dq[0]);
                    void'(dq.pop_front());
                end else begin
                    chk("unexpected_done", done, 0);
                end
            end else if (dq.size() > 0 && dq[0] == cyc) begin
                chk("done", done, 1);
                void'(dq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc <= cyc) begin
                if (rq[0].cyc == cyc) chk("rd_addr", rd_addr, rq[0].addr);
                else chk("rd_missing_cyc", cyc, rq[0].cyc);
                void'(rq.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [2:0] d,
                         input logic [6:0] cx, input logic [5:0] cy, output int n);
        @(negedge CLOCK_50);
        mode = m; density = d; cell_x = cx; cell_y = cy; start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        n = cyc;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((wq.size() > 0 || dq.size() > 0 || rq.size() > 0) && t < 6000) begin
            @(posedge CLOCK_50);
            t++;
        end
        @(posedge CLOCK_50);
    endtask

    // Cell k = y*W+x is written k cycles after acceptance using LFSR state S_k.
    task automatic model_sweep(input int n, input logic [1:0] m, input logic [2:0] d);
        for (int k = 0; k < N; k++) begin
            int   x, y;
            logic v;
            x = k % W;
            y = k / W;
            v = (m == 2'b01) && x > 0 && x < W - 1 && y > 0 && y < H - 1 && (m_lfsr[2:0] < d);
            wq.push_back('{n + k, k, v});
            grid[k] = v;
            m_lfsr = galois(m_lfsr);
        end
        dq.push_back(n + N);
        bf = n;
        bt = n + N;
    endtask

    task automatic do_sweep(input logic [1:0] m, input logic [2:0] d);
        int n;
        issue(m, d, 7'd0, 6'd0, n);
        model_sweep(n, m, d);
        wait_idle();
    endtask

    task automatic do_tog(input logic [6:0] cx, input logic [5:0] cy);
        int n, a, x, y;
        x = cx;
        y = cy;
        issue(2'b10, 3'd0, cx, cy, n);
        if (x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2) begin
            a = y * W + x;
            rq.push_back('{n, a});
            wq.push_back('{n + 1, a, !grid[a]});
            grid[a] = !grid[a];
            dq.push_back(n + 2);
            bf = n;
            bt = n + 2;
            rd_model = a;
        end else begin
            rq.push_back('{n, rd_model});
            dq.push_back(n);
        end
        wait_idle();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge CLOCK_50);
        #2 resetn = 1'b1;
        repeat (2) @(posedge CLOCK_50);

        do_sweep(2'b00, 3'd5);

        // Mode 11 sweeps as clear; a toggle request mid-sweep is dropped.
        issue(2'b11, 3'd7, 7'd0, 6'd0, n);
        model_sweep(n, 2'b11, 3'd7);
        while (cyc < n + 49) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        mode = 2'b10; cell_x = 7'd5; cell_y = 6'd5; start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        wait_idle();

        do_sweep(2'b01, 3'd0);
        do_tog(7'd5, 6'd5);
        do_tog(7'd5, 6'd5);
        do_tog(7'd0, 6'd10);
        do_tog(7'd79, 6'd3);
        do_tog(7'd100, 6'(70));

        do_sweep(2'b01, 3'd7);
        do_sweep(2'b01, 3'd3);
        do_sweep(2'b01, 3'($urandom_range(1, 6)));
        for (int i = 0; i < 12; i++)
            do_tog(7'($urandom_range(0, 85)), 6'($urandom_range(0, 61)));
        do_tog(7'd1, 6'd1);
        do_tog(7'd78, 6'd58);

        // Abort a sweep with reset; the LFSR must restart from its seed.
        issue(2'b01, 3'd4, 7'd0, 6'd0, n);
        model_sweep(n, 2'b01, 3'd4);
        while (cyc < n + 1000) @(posedge CLOCK_50);
        #2 resetn = 1'b0;
        wq.delete();
        dq.delete();
        rq.delete();
        bf = 0;
        bt = 0;
        m_lfsr = 16'hACE1;
        rd_model = 0;
        repeat (2) @(posedge CLOCK_50);
        #2 resetn = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        do_sweep(2'b01, 3'd7);
        do_tog(7'($urandom_range(1, 78)), 6'($urandom_range(1, 58)));

        fin = 1'b1;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog cyc=%0d got=no_finish expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
